// File: rtl/pio_poll_pkg.sv
// pio_poll_pkg: shared types and default widths for the PIO polling master.
//   state_e  - transaction FSM states
//   entry_t  - FIFO entry layout {data, ts} at default widths
//   DEF_*    - default parameter values used by pio_poll_master
package pio_poll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_e;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 2;
  localparam int DEF_PERIOD     = 1000;
  localparam int DEF_RD_LAT     = 1;
  localparam int DEF_TS_W       = 16;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_TS_W-1:0]   ts;
  } entry_t;

endpackage

// File: rtl/pio_poll_fifo.sv
// pio_poll_fifo: synchronous FIFO with registered head, no fall-through.
//   clk, reset  - clock, synchronous active-high reset
//   push_i      - write wdata_i (accepted if not full, or full with a pop)
//   pop_i       - consumer ready; pops the head when valid_o is high
//   wdata_i     - entry to write
//   rdata_o     - registered head entry, stable while not popped
//   valid_o     - FIFO non-empty
//   drop_o      - push refused because the FIFO was full with no pop
module pio_poll_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         valid_o,
  output logic         drop_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  head_q, head_d;
  logic          pop, push_ok;

  always_comb begin
    pop     = pop_i && (cnt_q != '0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_ok = push_i && ((cnt_q != FULL_CNT) || pop);
    drop_o  = push_i && !push_ok;
    cnt_d   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    head_d  = head_q;
    // Head register mirrors mem[rd]; refill it from the write path when the
    // FIFO is (or is about to become) empty, otherwise from the next slot.
    if (push_ok && ((cnt_q == '0) || (pop && (cnt_q == ONE_CNT))))
      head_d = wdata_i;
    else if (pop && (cnt_q > ONE_CNT))
      head_d = mem_q[rd_q + AW'(1)];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  assign rdata_o = head_q;
  assign valid_o = (cnt_q != '0);

endmodule

// File: rtl/pio_poll_master.sv
// pio_poll_master: periodically reads an input PIO over Avalon-MM, timestamps
// each sample and queues it on a valid/ready stream.
//   clk, reset        - clock, synchronous active-high reset
//   enable            - polling enabled while high
//   m_address/m_read  - read request (address constant 0, one-cycle strobe)
//   m_readdata        - responder data, valid RD_LAT cycles after m_read
//   s_valid/s_ready   - stream handshake for the FIFO head
//   s_data/s_ts       - sampled value and timestamp at the FIFO head
//   overflow          - sticky dropped-sample flag, cleared by clear_ovf
// Build option: PIO_POLL_CHANGE_ONLY_EN pushes a sample only when it differs
// from the previous capture (or is the first after reset).
module pio_poll_master
  import pio_poll_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int PERIOD     = DEF_PERIOD,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int TS_W       = DEF_TS_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  input  logic [DATA_W-1:0] m_readdata,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [DATA_W-1:0] s_data,
  output logic [TS_W-1:0]   s_ts,
  output logic              overflow,
  input  logic              clear_ovf
);

  state_e            state_q, state_d;
  logic [TS_W-1:0]   ts_q, ts_smp_q, ts_smp_d;
  logic [15:0]       per_q, per_d;
  logic [1:0]        wait_q, wait_d;
  logic              ovf_q, push, drop;
  logic [DATA_W+TS_W-1:0] head;

`ifdef PIO_POLL_CHANGE_ONLY_EN
  logic [DATA_W-1:0] last_q;
  logic              have_q;
`endif

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    wait_d   = wait_q;
    ts_smp_d = ts_smp_q;
    push     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!enable) per_d = '0;
        else if (per_q == 16'(PERIOD-1)) begin
          per_d   = '0;
          state_d = READ;
        end else per_d = per_q + 16'd1;
      end
      READ: begin
        ts_smp_d = ts_q;
        wait_d   = '0;
        state_d  = (RD_LAT == 1) ? CAPTURE : WAIT;
      end
      WAIT: begin
        // WAIT spans RD_LAT-1 cycles so CAPTURE lands RD_LAT after READ.
        if (int'(wait_q) >= RD_LAT-2) state_d = CAPTURE;
        else wait_d = wait_q + 2'd1;
      end
      CAPTURE: begin
`ifdef PIO_POLL_CHANGE_ONLY_EN
        push = !have_q || (m_readdata != last_q);
`else
        push = 1'b1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ts_q     <= '0;
      ts_smp_q <= '0;
      per_q    <= '0;
      wait_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_q + TS_W'(1);
      ts_smp_q <= ts_smp_d;
      per_q    <= per_d;
      wait_q   <= wait_d;
      // A drop in the same cycle as clear_ovf keeps the flag set.
      if (drop) ovf_q <= 1'b1;
      else if (clear_ovf) ovf_q <= 1'b0;
    end
  end

`ifdef PIO_POLL_CHANGE_ONLY_EN
  // Tracks every capture, including ones the FIFO drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      have_q <= 1'b0;
      last_q <= '0;
    end else if (state_q == CAPTURE) begin
      have_q <= 1'b1;
      last_q <= m_readdata;
    end
  end
`endif

  pio_poll_fifo #(.W(DATA_W+TS_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (s_ready),
    .wdata_i ({m_readdata, ts_smp_q}),
    .rdata_o (head),
    .valid_o (s_valid),
    .drop_o  (drop)
  );

  assign {s_data, s_ts} = head;
  assign m_read    = (state_q == READ);
  assign m_address = '0;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pio_poll_master.sv
// tb_pio_poll_master: two DUT instances (RD_LAT=1 and RD_LAT=3, PERIOD=4,
// depth 8, 8-bit timestamp so wraps occur) on shared stimulus. Each has a
// responder that drives valid data only RD_LAT cycles after m_read and a
// transaction-level model: a queue of expected {data, ts} entries.
module tb_pio_poll_master;

  localparam int PER = 4;
  localparam int DEP = 8;

  logic clk = 1'b0;
  logic reset, enable, s_ready, clear_ovf;
  logic script_en, const_en;
  logic [31:0] script [6];
  int vecs = 0, errs = 0;
  int pops [2];
  int reads [2];
  logic [1:0] mr, sv, ov;
  logic [31:0] sdat [2];
  logic [7:0]  sts  [2];

  typedef struct packed { logic [31:0] d; logic [7:0] t; } ent_t;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge inside a READ cycle of instance i.
  task automatic wait_read(input int i);
    int n = 0;
    while (!mr[i] && n < 100) begin @(negedge clk); n++; end
    if (!mr[i]) chk("wait_read_timeout", 0, 1);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic        m_read, s_valid, overflow;
    logic [1:0]  m_address;
    logic [31:0] m_readdata, s_data;
    logic [7:0]  s_ts;

    pio_poll_master #(.DATA_W(32), .ADDR_W(2), .PERIOD(PER), .RD_LAT(LAT),
                      .TS_W(8), .FIFO_DEPTH(DEP)) dut (
      .clk(clk), .reset(reset), .enable(enable), .m_address(m_address),
      .m_read(m_read), .m_readdata(m_readdata), .s_valid(s_valid),
      .s_ready(s_ready), .s_data(s_data), .s_ts(s_ts),
      .overflow(overflow), .clear_ovf(clear_ovf));

    assign mr[g] = m_read;
    assign sv[g] = s_valid;
    assign ov[g] = overflow;
    assign sdat[g] = s_data;
    assign sts[g]  = s_ts;

    // Responder: value valid only on the RD_LAT-th cycle after m_read.
    int cnt_r = 0, ridx = 0;
    logic [31:0] val_r = '0, junk = '0;
    assign m_readdata = (cnt_r == 1) ? val_r : junk;
    always @(posedge clk) begin
      junk <= $urandom;
      if (reset) cnt_r <= 0;
      else if (m_read) begin
        cnt_r <= LAT;
        val_r <= script_en ? script[(ridx < 6) ? ridx : 5] :
                 const_en  ? 32'hA5A5_0001 : $urandom;
      end else if (cnt_r > 0) cnt_r <= cnt_r - 1;
      if (reset || !script_en) ridx <= 0;
      else if (m_read) ridx <= ridx + 1;
    end

    // Reference model.
    ent_t q[$];
    int ts_m = 0, cyc = 0, last_rd = 0;
    logic [7:0] ts_rec = '0;
    bit ovf_m = 0, steady = 0, go = 0, pop = 0, push = 0, drop = 0;
    bit have_m = 0;
    logic [31:0] last_m = '0;

    initial forever begin
      @(posedge clk);
      if (reset) begin
        q.delete(); ts_m = 0; ovf_m = 0; steady = 0; have_m = 0; cyc = 0; go = 1;
      end else begin
        pop = s_ready && (q.size() > 0);
        if (s_valid && s_ready) pops[g]++;
        if (m_read) begin
          ts_rec = ts_m[7:0];
          if (steady) chk($sformatf("period%0d", g), cyc - last_rd, PER + LAT + 1);
          steady  = enable;
          last_rd = cyc;
          reads[g]++;
        end else if (!enable) steady = 0;
        drop = 0;
        if (pop) void'(q.pop_front());
        if (cnt_r == 1) begin
          push = 1;
`ifdef PIO_POLL_CHANGE_ONLY_EN
          push   = !have_m || (val_r != last_m);
          have_m = 1;
          last_m = val_r;
`endif
          if (push) begin
            if (q.size() == DEP) drop = 1;
            else q.push_back({val_r, ts_rec});
          end
        end
        if (drop) ovf_m = 1;
        else if (clear_ovf) ovf_m = 0;
        ts_m = (ts_m + 1) % 256;
        cyc++;
      end
    end

    initial forever begin
      @(negedge clk);
      if (go) begin
        chk($sformatf("s_valid%0d", g), s_valid, q.size() > 0);
        if (q.size() > 0) begin
          chk($sformatf("s_data%0d", g), s_data, q[0].d);
          chk($sformatf("s_ts%0d", g), s_ts, q[0].t);
        end
        chk($sformatf("overflow%0d", g), overflow, ovf_m);
        chk($sformatf("m_addr%0d", g), m_address, 0);
      end
    end
  end

  initial begin
    int p0, r0, n, thr;
    reset = 1; enable = 0; s_ready = 0; clear_ovf = 0;
    script_en = 0; const_en = 1;
    script = '{32'd5, 32'd5, 32'd5, 32'd7, 32'd7, 32'd5};
    pops = '{0, 0}; reads = '{0, 0};
    tick(3);
    for (int i = 0; i < 2; i++) begin
      chk("rst_mread", mr[i], 0);
      chk("rst_svalid", sv[i], 0);
      chk("rst_ovf", ov[i], 0);
      chk("rst_sdata", sdat[i], 0);
      chk("rst_sts", sts[i], 0);
    end
    reset = 0; enable = 1; s_ready = 1;

    // Steady polling of a constant value; model checks spacing and ts.
    tick(60);

    // Backpressure: fill, drop, overflow sticky.
    s_ready = 0;
    tick(100);
    chk("ovf_set0", ov[0], 1);
    chk("ovf_set1", ov[1], 1);
    enable = 0;
    tick(10);
    clear_ovf = 1; tick(1); clear_ovf = 0;
    chk("ovf_clr0", ov[0], 0);
    chk("ovf_clr1", ov[1], 0);

    // Full FIFO with a pop exactly on instance 0's capture cycle.
    enable = 1;
    wait_read(0);
    tick(1);
    s_ready = 1; enable = 0;
    tick(1);
    s_ready = 0;
    chk("full_pop_ovf", ov[0], 0);
    chk("full_pop_valid", sv[0], 1);
    tick(10);
    p0 = pops[0];
    s_ready = 1;
    tick(20);
    chk("full_cnt", pops[0] - p0, DEP);

    // Change-only sequence 5,5,5,7,7,5.
    script_en = 1;
    p0 = pops[0]; r0 = reads[0]; n = 0;
    enable = 1;
    while ((reads[0] - r0) < 6 && n < 200) begin tick(1); n++; end
    enable = 0;
    tick(20);
`ifdef PIO_POLL_CHANGE_ONLY_EN
    chk("chg_cnt", pops[0] - p0, 3);
`else
    chk("chg_cnt", pops[0] - p0, 6);
`endif
    script_en = 0; const_en = 0;

    // Reset during instance 1's WAIT with overflow set.
    enable = 1; s_ready = 0;
    tick(100);
    wait_read(1);
    tick(1);
    reset = 1;
    tick(1);
    for (int i = 0; i < 2; i++) begin
      chk("wrst_mread", mr[i], 0);
      chk("wrst_svalid", sv[i], 0);
      chk("wrst_ovf", ov[i], 0);
    end
    reset = 0;
    n = 0;
    while (!sv[1] && n < 50) begin tick(1); n++; end
    chk("wrst_ts0", sts[0], PER);
    chk("wrst_ts1", sts[1], PER);

    // Disable during WAIT: capture completes, then no reads.
    s_ready = 1;
    wait_read(1);
    tick(1);
    enable = 0;
    tick(6);
    p0 = reads[0]; r0 = reads[1];
    tick(40);
    chk("dis_reads0", reads[0] - p0, 0);
    chk("dis_reads1", reads[1] - r0, 0);

    // Randomized traffic.
    thr = 50;
    for (int c = 0; c < 2000; c++) begin
      if (c % 200 == 0) thr = $urandom_range(0, 100);
      s_ready   = ($urandom_range(0, 99) < thr);
      clear_ovf = ($urandom_range(0, 39) == 0);
      enable    = ($urandom_range(0, 19) != 0);
      tick(1);
    end
    s_ready = 1; clear_ovf = 0; enable = 0;
    tick(30);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
